// File: rtl/mem_fill_if.sv
// Bundle of the miss-request, memory-request, fill-steering and stall signals
// exchanged between the two caches, main memory and mem_fill_arbiter.
// Handshake: a cache raises *_miss and holds it (with its address) until it
// sees its fill_done_* pulse, and drops it on the following cycle. mem_en is a
// fire-and-forget read request. mem_data_valid returns exactly one word per
// request, in issue order, after any latency. The arbiter is the slave side.
interface mem_fill_if #(
    parameter int ADDR_W      = 16,
    parameter int BLOCK_WORDS = 8
);
    localparam int FW_W = $clog2(BLOCK_WORDS);

    logic              i_miss;
    logic [ADDR_W-1:0] i_miss_addr;
    logic              d_miss;
    logic [ADDR_W-1:0] d_miss_addr;
    logic              mem_data_valid;
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic              fill_we_i;
    logic              fill_we_d;
    logic [FW_W-1:0]   fill_word;
    logic              fill_done_i;
    logic              fill_done_d;
    logic              i_stall;
    logic              d_stall;
    logic              busy;
    logic [1:0]        state_dbg;

    modport slave (
        input  i_miss, i_miss_addr, d_miss, d_miss_addr, mem_data_valid,
        output mem_en, mem_addr, fill_we_i, fill_we_d, fill_word,
               fill_done_i, fill_done_d, i_stall, d_stall, busy, state_dbg
    );

    modport master (
        output i_miss, i_miss_addr, d_miss, d_miss_addr, mem_data_valid,
        input  mem_en, mem_addr, fill_we_i, fill_we_d, fill_word,
               fill_done_i, fill_done_d, i_stall, d_stall, busy, state_dbg
    );
endinterface

// File: rtl/mem_fill_arbiter.sv
// mem_fill_arbiter: shares one main memory between I-cache and D-cache block
// fills. Grants one pending miss, issues the block's word addresses on
// consecutive cycles, counts returned words and steers them to the owner.
// Optional build macro ARB_ROUND_ROBIN_EN: contended grants alternate based on
// the last served cache; without it the D-cache always wins a tie.
// state_dbg exposes the FSM state (0 idle, 1 fill, 2 done).
module mem_fill_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int BLOCK_WORDS = 8,
    parameter int WORD_BYTES  = 2
) (
    input  logic      clk,
    input  logic      rst,
    mem_fill_if.slave bus
);
    localparam int FW_W  = $clog2(BLOCK_WORDS);
    localparam int CNT_W = FW_W + 1;
    localparam int WB_SH = $clog2(WORD_BYTES);
    localparam int OFF_W = $clog2(BLOCK_WORDS * WORD_BYTES);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BLOCK_WORDS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  issue_cnt_q;
    logic [CNT_W-1:0]  recv_cnt_q;
    logic              owner_is_d_q;   // owner of the fill in progress
    logic [ADDR_W-1:0] base_q;
    logic              any_miss;
    logic              grant_d;
    logic [ADDR_W-1:0] grant_addr;

    assign any_miss   = bus.i_miss | bus.d_miss;
    assign grant_addr = grant_d ? bus.d_miss_addr : bus.i_miss_addr;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_is_d_q;

    // A tie goes to whichever cache was not served last.
    assign grant_d = bus.d_miss & (~bus.i_miss | ~last_is_d_q);

    // Remember the owner of each completed fill for the next tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_is_d_q <= 1'b0;
        end else if (state_q == ST_DONE) begin
            last_is_d_q <= owner_is_d_q;
        end
    end
`else
    // Fixed priority: D-cache misses stall the whole pipeline, so they win.
    assign grant_d = bus.d_miss;
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus issue/return/done outputs; everything idles at zero.
    always_comb begin
        state_d         = state_q;
        bus.mem_en      = 1'b0;
        bus.mem_addr    = '0;
        bus.fill_we_i   = 1'b0;
        bus.fill_we_d   = 1'b0;
        bus.fill_word   = '0;
        bus.fill_done_i = 1'b0;
        bus.fill_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_miss) state_d = ST_FILL;
            end
            ST_FILL: begin
                if (issue_cnt_q < CNT_FULL) begin
                    bus.mem_en   = 1'b1;
                    bus.mem_addr = base_q + (ADDR_W'(issue_cnt_q) << WB_SH);
                end
                if (bus.mem_data_valid) begin
                    bus.fill_we_i = ~owner_is_d_q;
                    bus.fill_we_d = owner_is_d_q;
                    bus.fill_word = recv_cnt_q[FW_W-1:0];
                    if (recv_cnt_q == CNT_LAST) state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                bus.fill_done_i = ~owner_is_d_q;
                bus.fill_done_d = owner_is_d_q;
                state_d         = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Grant latching and issue/receive counters; valids outside FILL are ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            issue_cnt_q  <= '0;
            recv_cnt_q   <= '0;
            owner_is_d_q <= 1'b0;
            base_q       <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_miss) begin
                        owner_is_d_q <= grant_d;
                        base_q       <= {grant_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        issue_cnt_q  <= '0;
                        recv_cnt_q   <= '0;
                    end
                end
                ST_FILL: begin
                    if (bus.mem_en)         issue_cnt_q <= issue_cnt_q + CNT_W'(1);
                    if (bus.mem_data_valid) recv_cnt_q  <= recv_cnt_q + CNT_W'(1);
                end
                ST_DONE: begin
                    issue_cnt_q <= '0;
                    recv_cnt_q  <= '0;
                end
                default: begin
                    issue_cnt_q <= '0;
                    recv_cnt_q  <= '0;
                end
            endcase
        end
    end

    // Stalls drop in the same cycle as the owner's done pulse; held low in reset.
    assign bus.i_stall   = rst & bus.i_miss & ~bus.fill_done_i;
    assign bus.d_stall   = rst & bus.d_miss & ~bus.fill_done_d;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Bench for mem_fill_arbiter: cache and memory models drive the interface,
// a block-level reference model queues the expected issue addresses,
// returned-word steering and done pulses, and a monitor checks them.
module tb_mem_fill_arbiter;
    localparam int ADDR_W    = 16;
    localparam int BW        = 8;
    localparam int WB        = 2;
    localparam int FW_W      = $clog2(BW);
    localparam int BLK_BYTES = BW * WB;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    mem_fill_if #(.ADDR_W(ADDR_W), .BLOCK_WORDS(BW)) bus ();

    mem_fill_arbiter #(.ADDR_W(ADDR_W), .BLOCK_WORDS(BW), .WORD_BYTES(WB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;
    logic [ADDR_W-1:0] exp_q[$];       // expected mem_addr sequence
    logic [FW_W:0]     exp_we_q[$];    // expected {is_d, fill_word}
    logic              exp_done_q[$];  // expected done owner (1 = D)
    logic              model_last_d = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        checks++;
        failures++;
        $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
    endtask

    // Reference model: a granted block produces BW consecutive word addresses,
    // BW returns steered to its owner with word 0..BW-1, then one done pulse.
    function automatic void push_block(input logic is_d, input logic [ADDR_W-1:0] addr);
        logic [ADDR_W-1:0] base;
        logic [FW_W-1:0]   wi;
        base = addr & ~ADDR_W'(BLK_BYTES - 1);
        for (int w = 0; w < BW; w++) begin
            wi = FW_W'(w);
            exp_q.push_back(base + ADDR_W'(w * WB));
            exp_we_q.push_back({is_d, wi});
        end
        exp_done_q.push_back(is_d);
        model_last_d = is_d;
    endfunction

    function automatic logic tie_goes_to_d();
`ifdef ARB_ROUND_ROBIN_EN
        return ~model_last_d;
`else
        return 1'b1;
`endif
    endfunction

    // ---------------- cache models ----------------
    int i_raise_seq = 0, d_raise_seq = 0, i_scr_seq = 0;
    logic [ADDR_W-1:0] i_raise_addr = '0, d_raise_addr = '0, i_scr_addr = '0;

    initial begin
        int   i_raise_done, d_raise_done, i_scr_done;
        logic di, dd;
        i_raise_done = 0; d_raise_done = 0; i_scr_done = 0;
        bus.i_miss = 1'b0; bus.i_miss_addr = '0;
        bus.d_miss = 1'b0; bus.d_miss_addr = '0;
        forever begin
            @(negedge clk);
            di = bus.fill_done_i;
            dd = bus.fill_done_d;
            @(posedge clk); #1;
            if (di) bus.i_miss = 1'b0;
            if (dd) bus.d_miss = 1'b0;
            if (i_raise_seq != i_raise_done) begin
                bus.i_miss = 1'b1; bus.i_miss_addr = i_raise_addr; i_raise_done = i_raise_seq;
            end
            if (d_raise_seq != d_raise_done) begin
                bus.d_miss = 1'b1; bus.d_miss_addr = d_raise_addr; d_raise_done = d_raise_seq;
            end
            if (i_scr_seq != i_scr_done) begin
                bus.i_miss_addr = i_scr_addr; i_scr_done = i_scr_seq;
            end
        end
    end

    // ---------------- memory model ----------------
    int fixed_lat  = 0;
    int inject_seq = 0;

    initial begin
        int due_q[$];
        int last_due, d, inject_done;
        last_due = 0; inject_done = 0;
        bus.mem_data_valid = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!rst) begin
                due_q.delete();
                bus.mem_data_valid = 1'b0;
            end else begin
                if (bus.mem_en) begin
                    d = cyc + ((fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 6)));
                    if (d <= last_due) d = last_due + 1;
                    last_due = d;
                    due_q.push_back(d);
                end
                bus.mem_data_valid = 1'b0;
                if (due_q.size() > 0 && due_q[0] == cyc) begin
                    void'(due_q.pop_front());
                    bus.mem_data_valid = 1'b1;
                end else if (inject_seq != inject_done) begin
                    inject_done = inject_seq;
                    bus.mem_data_valid = 1'b1;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    int we_total = 0;

    initial begin
        int blk_issued, last_issue;
        blk_issued = 0; last_issue = 0;
        forever begin
            @(negedge clk);
            if (!rst) blk_issued = 0;
            if (bus.mem_en) begin
                if (exp_q.size() == 0) fail_now("mem_addr", "request with nothing expected");
                else chk("mem_addr", 32'(bus.mem_addr), 32'(exp_q.pop_front()));
                if (blk_issued != 0) chk("issue_consecutive", 32'(cyc), 32'(last_issue + 1));
                last_issue = cyc;
                blk_issued = (blk_issued + 1) % BW;
                chk("busy_fill", 32'(bus.busy), 32'd1);
            end else begin
                chk("mem_addr_idle", 32'(bus.mem_addr), 32'd0);
            end
            if (bus.fill_we_i && bus.fill_we_d) fail_now("fill_we", "both caches written");
            if (bus.fill_we_i || bus.fill_we_d) begin
                we_total++;
                if (exp_we_q.size() == 0) fail_now("fill_we", "returned word with nothing expected");
                else chk("fill_owner_word", 32'({bus.fill_we_d, bus.fill_word}), 32'(exp_we_q.pop_front()));
            end
            if (bus.fill_done_i || bus.fill_done_d) begin
                if (exp_done_q.size() == 0) fail_now("fill_done", "done with nothing expected");
                else chk("fill_done_owner", 32'({bus.fill_done_i, bus.fill_done_d}),
                         exp_done_q.pop_front() ? 32'd1 : 32'd2);
            end
            chk("i_stall", 32'(bus.i_stall), 32'(rst & bus.i_miss & ~bus.fill_done_i));
            chk("d_stall", 32'(bus.d_stall), 32'(rst & bus.d_miss & ~bus.fill_done_d));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic raise_i(input logic [ADDR_W-1:0] a);
        push_block(1'b0, a);
        i_raise_addr = a;
        i_raise_seq++;
    endtask

    task automatic raise_d(input logic [ADDR_W-1:0] a);
        push_block(1'b1, a);
        d_raise_addr = a;
        d_raise_seq++;
    endtask

    task automatic raise_both(input logic [ADDR_W-1:0] ai, input logic [ADDR_W-1:0] ad);
        if (tie_goes_to_d()) begin
            push_block(1'b1, ad); push_block(1'b0, ai);
        end else begin
            push_block(1'b0, ai); push_block(1'b1, ad);
        end
        i_raise_addr = ai; i_raise_seq++;
        d_raise_addr = ad; d_raise_seq++;
    endtask

    task automatic wait_idle(input string name);
        for (int n = 0; n < 300; n++) begin
            @(negedge clk); #1;
            if (!bus.i_miss && !bus.d_miss && !bus.busy && exp_q.size() == 0 &&
                exp_we_q.size() == 0 && exp_done_q.size() == 0) return;
        end
        fail_now(name, "timeout waiting for fills to drain");
    endtask

    task automatic wait_we(input int target, input string name);
        for (int n = 0; n < 100; n++) begin
            @(negedge clk); #1;
            if (we_total >= target) return;
        end
        fail_now(name, "timeout waiting for returned words");
    endtask

    function automatic logic [31:0] all_outputs();
        return 32'({bus.mem_en, bus.mem_addr, bus.fill_we_i, bus.fill_we_d, bus.fill_word,
                    bus.fill_done_i, bus.fill_done_d, bus.i_stall, bus.d_stall, bus.busy});
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        logic [ADDR_W-1:0] a1, a2;
        int kind, start, gap;
        logic found;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", all_outputs(), 32'd0);
        @(posedge clk); #2; rst = 1'b1;

        // Single I miss, fixed latency, address changed after grant.
        @(negedge clk);
        fixed_lat = 4;
        raise_i(16'h1234);
        @(negedge clk);
        chk("t1_no_issue_before_grant", 32'(bus.mem_en), 32'd0);
        @(negedge clk);
        chk("t1_first_issue", 32'(bus.mem_en), 32'd1);
        i_scr_addr = 16'hFFFE; i_scr_seq++;
        wait_idle("t1_drain");
        fixed_lat = 0;

        // Simultaneous misses, then two more contended pairs.
        raise_both(16'h0040, 16'h8008);
        wait_idle("t2_drain");
        for (int p = 0; p < 2; p++) begin
            raise_both(ADDR_W'($urandom_range(0, 16'hFFFF)), ADDR_W'($urandom_range(0, 16'hFFFF)));
            wait_idle("t3_drain");
        end

        // D miss arrives after I word 2; served 2 cycles after the I done pulse.
        start = we_total;
        raise_i(16'h2468);
        wait_we(start + 3, "t4_words");
        raise_d(16'h9ABC);
        found = 1'b0;
        for (int n = 0; n < 60 && !found; n++) begin
            @(negedge clk); #1;
            if (bus.fill_done_i) found = 1'b1;
        end
        if (!found) fail_now("t4_done_i", "fill_done_i never seen");
        @(negedge clk);
        chk("t4_gap_idle", 32'(bus.mem_en), 32'd0);
        @(negedge clk);
        chk("t4_d_first_issue", 32'(bus.mem_en), 32'd1);
        wait_idle("t4_drain");

        // Reset with three words received; the block refetches from word 0.
        start = we_total;
        raise_i(16'h4C2A);
        wait_we(start + 3, "t5_words");
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        chk("t5_reset_outputs", all_outputs(), 32'd0);
        exp_q.delete(); exp_we_q.delete(); exp_done_q.delete();
        model_last_d = 1'b0;
        repeat (2) @(negedge clk);
        chk("t5_reset_held", all_outputs(), 32'd0);
        @(posedge clk); #2;
        rst = 1'b1;
        push_block(1'b0, 16'h4C2A);
        wait_idle("t5_drain");

        // Stray memory valid while idle.
        inject_seq++;
        @(negedge clk);
        @(negedge clk);
        chk("t6_idle_valid_ignored",
            32'({bus.fill_we_i, bus.fill_we_d, bus.fill_done_i, bus.fill_done_d, bus.busy}), 32'd0);
        raise_d(16'h7777);
        wait_idle("t6_drain");

        // Randomized scenarios.
        for (int s = 0; s < 25; s++) begin
            kind = $urandom_range(0, 3);
            a1 = ADDR_W'($urandom_range(0, 16'hFFFF));
            a2 = ADDR_W'($urandom_range(0, 16'hFFFF));
            case (kind)
                0: raise_i(a1);
                1: raise_d(a1);
                2: raise_both(a1, a2);
                default: begin
                    gap = $urandom_range(1, 7);
                    if ($urandom_range(0, 1) == 1) begin
                        raise_i(a1);
                        repeat (gap) @(negedge clk);
                        raise_d(a2);
                    end else begin
                        raise_d(a1);
                        repeat (gap) @(negedge clk);
                        raise_i(a2);
                    end
                end
            endcase
            wait_idle("rand_drain");
        end

        chk("final_addr_q_empty", 32'(exp_q.size()), 32'd0);
        chk("final_we_q_empty", 32'(exp_we_q.size()), 32'd0);
        chk("final_done_q_empty", 32'(exp_done_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
